tff_toggle_receiver: RTL
========================

# tff_toggle_receiver

Receiving end of the toggle-encoded event link driven by the team's T flip-flop transmitter, whose Q output inverts once per event. The block synchronises the incoming toggle level and converts every level change back into a discrete event. It buffers events in a saturating pending counter and hands them one at a time to the consumer over a valid/ready handshake. It sits between the TFF-based event source and the downstream logic that consumes events.

## Interface
- SYNC_STAGES, default 2: synchroniser depth; legal values are 2–4.
- PEND_W, default 3: pending counter width; up to 2^PEND_W−1 events are buffered.
- TOTAL_W, default 8: width of the free-running total event counter.
- clk  input  1  the single clock; all state updates on the rising edge.
- asyncReset  input  1  asynchronous, active-high reset; it clears all state immediately.
- toggleIn  input  1  toggle-encoded event line, i.e. the transmitter's Q.
- eventValid  output  1  high while at least one event is pending.
- eventReady  input  1  consumer accepts one event when this and eventValid are both high at a clk edge.
- pendingCount  output  PEND_W  number of events buffered and not yet accepted.
- totalCount  output  TOTAL_W  events detected since reset, modulo 2^TOTAL_W.
- overflow  output  1  sticky flag: an event was dropped because the buffer was full.
- clearOverflow  input  1  synchronous clear for overflow.

## Operation
- Reset values:
  - sync chain = 0
  - prevLevel = 0
  - pendingCount = 0
  - totalCount = 0
  - overflow = 0
  - eventValid = 0
- The transmitter must reset its Q to 0 so that levels agree after reset.
- Synchroniser: toggleIn passes through SYNC_STAGES flops to become syncLevel. prevLevel registers syncLevel every cycle.
- Event detect: eventPulse = syncLevel XOR prevLevel, which is combinational. There is one pulse per level change, in either direction.
- Accept: accept = eventValid AND eventReady.
- Pending update, priority per clk edge:
  - eventPulse and accept together: pending unchanged.
  - eventPulse only, pending < max: pending + 1.
  - eventPulse only, pending == max: pending unchanged, the event is dropped, overflow is set to 1.
  - accept only: pending − 1.
  - Otherwise: hold.
- totalCount increments on every eventPulse, including dropped events, and wraps from 2^TOTAL_W−1 to 0.
- eventValid = (pendingCount != 0), registered-derived with no combinational path from eventReady.
- eventReady while eventValid = 0 has no effect, and pending never underflows.
- overflow clear:
  - clearOverflow clears overflow at the next edge.
  - If a drop occurs in the same cycle, set wins and overflow stays 1.
- asyncReset asserted mid-operation discards all pending events and returns every output to its reset value within the same cycle, without waiting for a clock edge.

## Timing
- A toggleIn change first sampled at edge k reaches syncLevel after edge k+SYNC_STAGES−1.
- eventPulse is high during the following cycle. pendingCount and eventValid update at edge k+SYNC_STAGES.
- Latency from the sampling edge to eventValid is SYNC_STAGES cycles: 2 with the defaults.
- Throughput:
  - Same-clock source: one event per cycle, i.e. toggleIn may change every cycle.
  - Asynchronous source: each level must be held for at least 2 clk periods.
- Handshake: eventValid is independent of eventReady in the same cycle. After acceptance of the last event, eventValid falls at that edge.
- Back-to-back accepts drain one event per cycle.

## Structure
- Shared package tff_link_pkg holds:
  - the TFF_RESET_LEVEL constant (1'b0), used by both transmitter and receiver;
  - the default SYNC_STAGES, PEND_W and TOTAL_W values.
- Sub-module toggle_sync contains:
  - the SYNC_STAGES flop chain;
  - prevLevel;
  - the eventPulse output.
- The top level holds the pending counter, total counter, overflow flag and handshake logic.

## Test plan
- **Single event:** after reset, toggleIn 0→1 with eventReady=0 → eventValid=1 and pendingCount=1 two cycles later, totalCount=1. Then eventReady=1 for one cycle → pendingCount=0, eventValid=0.
- **Both directions:** toggleIn 0→1→0→1, each level held 3 cycles, with eventReady=0 → pendingCount=3, totalCount=3.
- **Overflow:** PEND_W=3, 9 toggles with eventReady=0 → pendingCount=7, overflow=1, totalCount=9. Then clearOverflow for one cycle → overflow=0, pendingCount still 7.
- **Simultaneous event and accept:** pendingCount=2, eventReady=1 held, and a toggle arriving in the same cycle as an accept → pendingCount stays 2 in that cycle, then drains to 0 one per cycle.
- **Async reset mid-operation:** pendingCount=5, overflow=1, asserting asyncReset between edges → all outputs 0 immediately. After release, toggleIn held at 0 → no spurious event.
- **Wrap-around:** TOTAL_W=8, 257 toggles with eventReady=1 held → totalCount=1, overflow=0.

Source files
------------

// File: rtl/tff_toggle_receiver_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tff_link_pkg: constants shared by the TFF event-link endpoints.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tff_link_pkg;

  // Transmitter Q and receiver synchroniser must agree on this after reset.
  localparam logic TFF_RESET_LEVEL = 1'b0;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 3;
  localparam int DEF_TOTAL_W     = 8;

endpackage
`default_nettype wire

// File: rtl/tff_toggle_receiver_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tff_toggle_receiver_if: toggle line, event handshake and status. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface tff_toggle_receiver_if
  import tff_link_pkg::*;
#(
  parameter int PEND_W  = DEF_PEND_W,
  parameter int TOTAL_W = DEF_TOTAL_W
);
  logic               toggleIn;
  logic               eventValid;
  logic               eventReady;
  logic [PEND_W-1:0]  pendingCount;
  logic [TOTAL_W-1:0] totalCount;
  logic               overflow;
  logic               clearOverflow;

  // Receiver side
  modport slave (
    input  toggleIn, eventReady, clearOverflow,
    output eventValid, pendingCount, totalCount, overflow
  );

  // Source/consumer side
  modport master (
    output toggleIn, eventReady, clearOverflow,
    input  eventValid, pendingCount, totalCount, overflow
  );
endinterface
`default_nettype wire

// File: rtl/tff_toggle_receiver_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | toggle_sync: synchronises the toggle level, pulses on each edge. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module toggle_sync
  import tff_link_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  wire logic clk,
  input  wire logic asyncReset,
  input  wire logic toggle_i,
  output logic      pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], toggle_i};

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      sync_q <= {SYNC_STAGES{TFF_RESET_LEVEL}};
      prev_q <= TFF_RESET_LEVEL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Either direction of level change is one event.
  assign pulse_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule
`default_nettype wire

// File: rtl/tff_toggle_receiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tff_toggle_receiver: toggle-link events -> buffered valid/ready. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tff_toggle_receiver
  import tff_link_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int TOTAL_W     = DEF_TOTAL_W
) (
  input  wire logic             clk,
  input  wire logic             asyncReset,
  tff_toggle_receiver_if.slave  bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic               eventPulse;
  logic               eventValid;
  logic               accept;
  logic               drop;
  logic [PEND_W-1:0]  pend_q,  pend_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               ovf_q,   ovf_d;

  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .asyncReset (asyncReset),
    .toggle_i   (bus.toggleIn),
    .pulse_o    (eventPulse)
  );

  // Valid comes straight from the counter, never from eventReady.
  assign eventValid = (pend_q != '0);
  assign accept     = eventValid & bus.eventReady;

  always_comb begin
    pend_d  = pend_q;
    drop    = 1'b0;
    if (eventPulse && !accept) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!eventPulse && accept) begin
      pend_d = pend_q - 1'b1;
    end
    total_d = total_q + TOTAL_W'(eventPulse);
    ovf_d   = drop | (ovf_q & ~bus.clearOverflow);
  end

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      pend_q  <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.eventValid   = eventValid;
  assign bus.pendingCount = pend_q;
  assign bus.totalCount   = total_q;
  assign bus.overflow     = ovf_q;

endmodule
`default_nettype wire
